// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef struct packed {
        logic overrun;
        logic frame_err;
    } uart_status_t;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// The head entry is presented combinationally from the storage array; rdata
// is forced to zero while empty. Pointers carry one extra wrap bit so that
// full and empty are distinguished by occupancy alone.
module uart_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [Width-1:0]       wdata,
    output logic [Width-1:0]       rdata,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];

    // Next-pointer computation; pointers wrap naturally at 2*Depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + CW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + CW'(1);
    end

    // Pointer registers, cleared by reset so queued entries are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; no reset needed since reads are gated by occupancy.
    // A push while full is only issued alongside a pop, so overwriting the
    // head slot here coincides with that head leaving the FIFO.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    // Occupancy flags and the fall-through head.
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        full  = (count == CW'(Depth));
        empty = (count == '0);
        rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

endmodule : uart_sync_fifo

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures completed
// bytes into a FWFT FIFO, and keeps sticky overrun / framing-error flags
// plus a saturating count of receiver error edges.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned Depth         = 8,
    parameter int unsigned ErrCountWidth = 8
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     rxDone,
    input  byte_t                    rxData,
    input  logic                     rxErr,
    output byte_t                    data,
    output logic                     valid,
    input  logic                     ready,
    output logic [$clog2(Depth):0]   count,
    output logic                     full,
    output logic                     overrun,
    output logic                     frameErr,
    output logic [ErrCountWidth-1:0] errCount,
    input  logic                     clearErr
);

    logic                     push_pend_q, push_pend_d;
    logic                     rx_err_q, rx_err_d;
    uart_status_t             status_q, status_d;
    logic [ErrCountWidth-1:0] err_count_q, err_count_d;

    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;
    logic err_edge;

    uart_sync_fifo #(
        .Width (8),
        .Depth (Depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (nReset),
        .push  (push),
        .pop   (pop),
        .wdata (rxData),
        .rdata (data),
        .count (count),
        .full  (full),
        .empty (fifo_empty)
    );

    // Push/pop qualification, error edge detect and sticky status next-state.
    // A new event in the same cycle as clearErr takes precedence over the clear.
    always_comb begin
        valid       = !fifo_empty;
        pop         = valid && ready;
        push        = push_pend_q && (!full || pop);
        drop        = push_pend_q && full && !pop;
        err_edge    = rxErr && !rx_err_q;

        push_pend_d = rxDone;
        rx_err_d    = rxErr;

        status_d    = status_q;
        err_count_d = err_count_q;
        if (clearErr) begin
            status_d    = '0;
            err_count_d = '0;
        end
        if (drop) status_d.overrun = 1'b1;
        if (err_edge) begin
            status_d.frame_err = 1'b1;
            if (clearErr) begin
                err_count_d = ErrCountWidth'(1);
            end else if (err_count_q != '1) begin
                err_count_d = err_count_q + ErrCountWidth'(1);
            end
        end
    end

    // Pulse, edge-detect and status registers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            push_pend_q <= 1'b0;
            rx_err_q    <= 1'b0;
            status_q    <= '0;
            err_count_q <= '0;
        end else begin
            push_pend_q <= push_pend_d;
            rx_err_q    <= rx_err_d;
            status_q    <= status_d;
            err_count_q <= err_count_d;
        end
    end

    assign overrun  = status_q.overrun;
    assign frameErr = status_q.frame_err;
    assign errCount = err_count_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model is
// compared against the DUT on every falling clock edge, with directed
// scenarios carrying hand-computed literal expectations.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       rxDone = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic       rxErr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b0;
    logic [3:0] count;
    logic       full;
    logic       overrun;
    logic       frameErr;
    logic [7:0] errCount;
    logic       clearErr = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    bit running = 1'b1;

    uart_rx_fifo #(
        .Depth         (8),
        .ErrCountWidth (8)
    ) dut (
        .clk      (clk),
        .nReset   (nReset),
        .rxDone   (rxDone),
        .rxData   (rxData),
        .rxErr    (rxErr),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .count    (count),
        .full     (full),
        .overrun  (overrun),
        .frameErr (frameErr),
        .errCount (errCount),
        .clearErr (clearErr)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded byte queue plus plain flags and a counter.
    byte unsigned mq[$];
    bit           m_pend = 0;
    bit           m_err_prev = 0;
    bit           m_ov = 0;
    bit           m_fe = 0;
    int           m_cnt = 0;

    task automatic model_clear();
        mq.delete();
        m_pend = 0; m_err_prev = 0; m_ov = 0; m_fe = 0; m_cnt = 0;
    endtask

    always @(negedge nReset) model_clear();

    always @(posedge clk) begin
        if (!nReset) begin
            model_clear();
        end else begin
            int  sz;
            bit  do_pop, drop, edge_seen;
            sz        = mq.size();
            do_pop    = (sz > 0) && ready;
            drop      = 0;
            edge_seen = rxErr && !m_err_prev;
            if (do_pop) void'(mq.pop_front());
            if (m_pend) begin
                if (sz < 8 || do_pop) mq.push_back(rxData);
                else drop = 1;
            end
            if (clearErr) begin
                m_ov  = drop;
                m_fe  = edge_seen;
                m_cnt = edge_seen ? 1 : 0;
            end else begin
                m_ov = m_ov | drop;
                m_fe = m_fe | edge_seen;
                if (edge_seen && m_cnt < 255) m_cnt = m_cnt + 1;
            end
            m_err_prev = rxErr;
            m_pend     = rxDone;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (running) begin
            int exp_data;
            exp_data = (mq.size() != 0) ? int'(mq[0]) : 0;
            check("model_data",     int'(data),     exp_data);
            check("model_valid",    int'(valid),    int'(mq.size() != 0));
            check("model_count",    int'(count),    mq.size());
            check("model_full",     int'(full),     int'(mq.size() == 8));
            check("model_overrun",  int'(overrun),  int'(m_ov));
            check("model_frameErr", int'(frameErr), int'(m_fe));
            check("model_errCount", int'(errCount), m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulse rxDone, then hold the byte during the push cycle; returns
    // one time unit after the write edge.
    task automatic send_byte(input logic [7:0] b);
        rxDone = 1'b1;
        cyc();
        rxDone = 1'b0;
        rxData = b;
        cyc();
    endtask

    task automatic clear_flags();
        clearErr = 1'b1;
        cyc();
        clearErr = 1'b0;
    endtask

    logic [7:0] exp_order [8];

    initial begin
        #12;
        nReset = 1'b1;
        cyc();

        // Reset state.
        check("rst_valid", int'(valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_errCount", int'(errCount), 0);

        // Single byte through an empty FIFO.
        send_byte(8'hA5);
        check("single_valid", int'(valid), 1);
        check("single_data", int'(data), 8'hA5);
        check("single_count", int'(count), 1);
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        check("single_pop_valid", int'(valid), 0);
        check("single_pop_data", int'(data), 0);

        // Fill, then overrun with a ninth byte.
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i));
            cyc();
        end
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 8);
        send_byte(8'hFF);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_count", int'(count), 8);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovr_drain", int'(data), i);
            cyc();
        end
        ready = 1'b0;
        check("ovr_drained_valid", int'(valid), 0);
        clear_flags();
        check("clear_overrun", int'(overrun), 0);

        // Full with a pop coinciding with the ninth push.
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h10 + 8'(i));
        end
        check("fp_full", int'(full), 1);
        rxDone = 1'b1;
        cyc();
        rxDone = 1'b0;
        rxData = 8'h99;
        ready  = 1'b1;
        cyc();
        ready  = 1'b0;
        check("fp_no_overrun", int'(overrun), 0);
        check("fp_count", int'(count), 8);
        for (int i = 0; i < 7; i++) exp_order[i] = 8'h11 + 8'(i);
        exp_order[7] = 8'h99;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("fp_drain", int'(data), int'(exp_order[i]));
            cyc();
        end
        ready = 1'b0;
        check("fp_empty", int'(valid), 0);

        // Error edges: a 3-cycle level then a 1-cycle pulse count twice.
        clear_flags();
        rxErr = 1'b1; cyc(); cyc(); cyc();
        rxErr = 1'b0; cyc();
        rxErr = 1'b1; cyc();
        rxErr = 1'b0; cyc();
        check("err_count2", int'(errCount), 2);
        check("err_flag", int'(frameErr), 1);
        for (int i = 0; i < 300; i++) begin
            rxErr = 1'b1; cyc();
            rxErr = 1'b0; cyc();
        end
        check("err_saturate", int'(errCount), 255);

        // Clear colliding with a new error edge.
        clearErr = 1'b1;
        rxErr    = 1'b1;
        cyc();
        clearErr = 1'b0;
        rxErr    = 1'b0;
        check("collide_flag", int'(frameErr), 1);
        check("collide_count", int'(errCount), 1);

        // Reset mid-operation with bytes queued and flags set.
        send_byte(8'h31);
        send_byte(8'h32);
        send_byte(8'h33);
        check("pre_rst_count", int'(count), 3);
        #2;
        nReset = 1'b0;
        #1;
        check("arst_valid", int'(valid), 0);
        check("arst_data", int'(data), 0);
        check("arst_count", int'(count), 0);
        check("arst_frameErr", int'(frameErr), 0);
        check("arst_errCount", int'(errCount), 0);
        cyc();
        nReset = 1'b1;
        cyc();
        send_byte(8'h44);
        check("post_rst_data", int'(data), 8'h44);
        check("post_rst_count", int'(count), 1);
        ready = 1'b1;
        cyc();
        ready = 1'b0;

        // Randomized traffic, including back-to-back rxDone pulses.
        for (int i = 0; i < 3000; i++) begin
            rxDone = ($urandom_range(0, 2) == 0);
            rxData = 8'($urandom);
            ready  = ($urandom_range(0, 2) != 0) ? (i % 400 < 250) : 1'b0;
            if ($urandom_range(0, 3) == 0) rxErr = ~rxErr;
            clearErr = ($urandom_range(0, 15) == 0);
            cyc();
        end
        rxDone = 1'b0;
        ready  = 1'b0;
        clearErr = 1'b0;
        rxErr = 1'b0;
        cyc();
        cyc();

        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the oversampling UART receiver. Captures each byte the receiver completes, queues it in a small synchronous FIFO, and presents it to the consumer over a first-word-fall-through valid/ready interface. Also tracks receiver framing errors and FIFO overruns as sticky status plus a saturating error count, so software-facing logic can poll line health without watching single-cycle pulses.

## Interface
- `Depth`, 8: FIFO entries; power of two, at least 2.
- `ErrCountWidth`, 8: width of the saturating framing-error counter.

- `clk`  in  1  system clock.
- `nReset`  in  1  asynchronous active-low reset.
- `rxDone`  in  1  one-cycle pulse from the receiver: a byte has completed.
- `rxData`  in  8  receiver data register; valid from the cycle after `rxDone` until the next byte completes.
- `rxErr`  in  1  receiver error indication; level, may stay high for more than one cycle.
- `data`  out  8  head-of-FIFO byte; 0 when empty.
- `valid`  out  1  FIFO non-empty.
- `ready`  in  1  consumer accepts `data` when `valid && ready`.
- `count`  out  $clog2(Depth)+1  current occupancy, 0..Depth.
- `full`  out  1  `count == Depth`.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frameErr`  out  1  sticky: receiver error seen.
- `errCount`  out  ErrCountWidth  number of `rxErr` rising edges; saturates at all-ones.
- `clearErr`  in  1  synchronous clear of `overrun`, `frameErr` and `errCount`.

## Operation
- Clock is `clk`. Reset is asynchronous and active-low on `nReset`. Reset puts every output into its reset value: `data`=0, `valid`=0, `count`=0, `full`=0, `overrun`=0, `frameErr`=0, `errCount`=0. Pointers and internal pulse registers are also cleared. Reset taken mid-operation discards all queued bytes.
- Capture: `rxDone` is registered into `pushPend`. In the cycle `pushPend`=1, `rxData` is written to `mem[wrPtr]`. That is the cycle after the `rxDone` pulse.
- Push condition is `pushPend && (!full || pop)`. `pop` = `valid && ready`.
- Push with `full` and no pop: the byte is dropped, `overrun` is set, and pointers are unchanged.
- Pointers are `$clog2(Depth)+1` bits wide and wrap naturally. `count = wrPtr - rdPtr`, and `valid = (count != 0)`.
- Simultaneous push and pop:
  - When full: both take effect, `count` stays at Depth, and there is no overrun.
  - When empty: not possible, since `valid`=0 means there is no pop. The push occurs and the byte becomes visible the next cycle.
- `data = valid ? mem[rdPtr] : 0`. This is combinational from registered state, so there is no output register.
- Error tracking: a rising edge of `rxErr` is detected against a registered copy that resets to 0. Each edge sets `frameErr` and increments `errCount`. The counter saturates and never wraps. A level held high counts once.
- Bytes are never tagged or removed because of errors. A byte pushed just before a stop-bit error stays queued.
- `clearErr` clears all three status fields. If a new error edge or overrun occurs in the same cycle as `clearErr`, the new event wins: the flag ends at 1 and `errCount` ends at 1.
- There is no state machine beyond the pointer and flag registers. The block is a pure datapath with sticky status.

## Timing
- Latency from `rxDone` pulse (cycle N) to write (N+1) to `valid`/`data` visible (N+2) is 2 cycles when empty.
- The pop removes the head at the clock edge. The next entry, or `valid`=0, appears the following cycle.
- `count`, `full` and the status fields all update at the same edge as the push or pop that causes them.
- `rxDone` pulses at least one full byte time apart, so back-to-back `pushPend` never occurs. The block must still handle consecutive pulses correctly, one push per pulse.

## Structure
- Shared package `uart_pkg`: `byte_t` (logic [7:0]) and a `uart_status_t` packed struct {overrun, frameErr}.
- One sub-module is natural: `uart_sync_fifo`, a generic parameterised FWFT FIFO carrying memory, pointers, count and full/empty.
- `uart_rx_fifo` itself holds the push-pending register, drop/overrun logic, error edge detect, the counter and the clear logic.

## Test plan
- Single byte: pulse `rxDone` with `rxData`=0xA5 held from the next cycle, `ready`=0. Expect `valid`=1, `data`=0xA5, `count`=1 two cycles later. Then `ready`=1 for one cycle: expect `valid`=0, `data`=0.
- Fill and overrun: 8 bytes 0x00..0x07, `ready`=0. Expect `full`=1. A 9th byte 0xFF gives `overrun`=1, `count`=8, and draining yields 0x00..0x07 in order with 0xFF absent.
- Full with concurrent pop: FIFO full, 9th byte's push cycle coincides with `ready`=1. Expect no overrun, `count` stays 8, and the drained order ends with the 9th byte.
- Error edges: `rxErr` high 3 cycles, low, then high 1 cycle. Expect `errCount`=2 and `frameErr`=1. Drive 300 edges with width 8: expect saturation at 255.
- Clear collision: `clearErr` in the same cycle as an `rxErr` rising edge. Expect `frameErr`=1 and `errCount`=1 afterwards.
- Reset mid-operation: 3 bytes queued with flags set, then assert `nReset` low asynchronously between edges. All outputs go to reset values immediately, and the first byte after release is the first byte read.
